// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner bundle: column sense lines in, row strobes and key events out.
interface keypad_matrix_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: rotates row strobes, snapshots a whole frame of
// columns and debounces press/release over consecutive identical frames.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                    m_clk,
    input  logic                    Reset,
    keypad_matrix_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_LAST) ? c : c + CNT_ONE;
    endfunction

    logic [3:0]       col_p0, col_p1;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_index;
    logic [3:0]       row_q;
    logic [15:0]      snapshot;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;

    logic             tc;
    logic             frame_end;
    logic [15:0]      frame_bits;
    logic [4:0]       n_set;
    logic [3:0]       hit_code;
    logic             frame_none;
    logic             frame_single;

    assign tc        = (div == DIV_LAST);
    assign frame_end = tc && (row_index == 2'd3);

    // Current row's sample is merged in so the frame-end decision sees all 16 keys.
    always_comb begin
        frame_bits = snapshot | ({12'b0, ~col_p1} << {row_index, 2'b00});
        n_set      = '0;
        hit_code   = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_bits[i]) begin
                n_set    = n_set + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    assign frame_none   = (n_set == 5'd0);
    assign frame_single = (n_set == 5'd1);

    // Stage p0/p1: column synchroniser, then row divider and frame snapshot
    always_ff @(posedge m_clk or negedge Reset) begin
        if (!Reset) begin
            col_p0    <= 4'b1111;
            col_p1    <= 4'b1111;
            div       <= '0;
            row_index <= 2'd0;
            row_q     <= 4'b1110;
            snapshot  <= '0;
        end else begin
            col_p0 <= kp.col;
            col_p1 <= col_p0;
            if (tc) begin
                div       <= '0;
                row_index <= row_index + 2'd1;
                row_q     <= ~(4'b0001 << (row_index + 2'd1));
                snapshot  <= frame_end ? 16'h0000 : frame_bits;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Debounce FSM, advanced once per frame
    always_ff @(posedge m_clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (frame_single) begin
                            cand <= hit_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                state       <= PRESSED;
                                cnt         <= '0;
                                key_code_q  <= hit_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (frame_single && hit_code == cand) begin
                            if (sat_inc(cnt) == CNT_LAST) begin
                                state       <= PRESSED;
                                cnt         <= '0;
                                key_code_q  <= cand;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
                        end else if (frame_single) begin
                            cand <= hit_code;
                            cnt  <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (frame_none) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state      <= IDLE;
                                cnt        <= '0;
                                key_held_q <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (frame_none) begin
                            if (sat_inc(cnt) == CNT_LAST) begin
                                state      <= IDLE;
                                cnt        <= '0;
                                key_held_q <= 1'b0;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
                        end else begin
                            // Contact bounce during release: resume the held key silently.
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign kp.row       = row_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule
